// File: rtl/fsic_is_tx_arbiter_pkg.sv
// Shared types for the IO_SERDES TX packet arbiter.
// State encoding, side-band widths and the pointer wrap helper.
package fsic_is_tx_arbiter_pkg;

  localparam int TID_W  = 2;
  localparam int USER_W = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [TID_W-1:0] next_ptr(
    input logic [TID_W-1:0] g,
    input int               n
  );
    if (int'(g) >= n - 1) return '0;
    return g + 1'b1;
  endfunction

endpackage

// File: rtl/fsic_is_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Returns the first requesting index at or after ptr, wrapping.
module fsic_is_tx_arbiter_rr_pick
  import fsic_is_tx_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [TID_W-1:0] ptr,
  output logic [TID_W-1:0] idx,
  output logic             any
);

  int c;

  always_comb begin
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!any && req[c]) begin
        any = 1'b1;
        idx = TID_W'(c);
      end
    end
  end

endmodule

// File: rtl/fsic_is_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the IO_SERDES TX stream.
// Grant locks from first beat to tlast; one registered output stage.
module fsic_is_tx_arbiter
  import fsic_is_tx_arbiter_pkg::*;
#(
  parameter int pNUM_REQ    = 4,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                              axis_clk,
  input  logic                              axis_rst_n,
  input  logic                              arb_en,
  input  logic [pNUM_REQ*pDATA_WIDTH-1:0]   req_tdata,
  input  logic [pNUM_REQ*pDATA_WIDTH/8-1:0] req_tstrb,
  input  logic [pNUM_REQ*pDATA_WIDTH/8-1:0] req_tkeep,
  input  logic [pNUM_REQ*USER_W-1:0]        req_tuser,
  input  logic [pNUM_REQ-1:0]               req_tlast,
  input  logic [pNUM_REQ-1:0]               req_tvalid,
  output logic [pNUM_REQ-1:0]               req_tready,
  output logic [pDATA_WIDTH-1:0]            as_is_tdata,
  output logic [pDATA_WIDTH/8-1:0]          as_is_tstrb,
  output logic [pDATA_WIDTH/8-1:0]          as_is_tkeep,
  output logic [USER_W-1:0]                 as_is_tuser,
  output logic [TID_W-1:0]                  as_is_tid,
  output logic                              as_is_tlast,
  output logic                              as_is_tvalid,
  input  logic                              is_as_tready,
  output logic [TID_W-1:0]                  cur_owner,
  output logic                              busy
);

  localparam int SW = pDATA_WIDTH / 8;

  arb_state_e state_q, state_d;
  logic [TID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TID_W-1:0] owner_q, owner_d;

  logic [pDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [SW-1:0]          tstrb_q, tstrb_d;
  logic [SW-1:0]          tkeep_q, tkeep_d;
  logic [USER_W-1:0]      tuser_q, tuser_d;
  logic [TID_W-1:0]       tid_q, tid_d;
  logic                   tlast_q, tlast_d;
  logic                   tvalid_q, tvalid_d;

  logic             load_en;
  logic [TID_W-1:0] pick_idx;
  logic             pick_any;
  logic [TID_W-1:0] gnt;
  logic             gnt_vld;
  logic             accept;

  fsic_is_tx_arbiter_rr_pick #(
    .N (pNUM_REQ)
  ) u_pick (
    .req (req_tvalid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign load_en = !tvalid_q || is_as_tready;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    tdata_d    = tdata_q;
    tstrb_d    = tstrb_q;
    tkeep_d    = tkeep_q;
    tuser_d    = tuser_q;
    tid_d      = tid_q;
    tlast_d    = tlast_q;
    tvalid_d   = tvalid_q && !is_as_tready;
    req_tready = '0;
    gnt        = '0;
    gnt_vld    = 1'b0;
    accept     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_en && pick_any) begin
          gnt     = pick_idx;
          gnt_vld = 1'b1;
        end
      end
      LOCKED: begin
        gnt     = owner_q;
        gnt_vld = 1'b1;
      end
      default: ;
    endcase

    // Ready is forced low while reset is asserted.
    if (gnt_vld && axis_rst_n) begin
      req_tready[gnt] = load_en;
      accept          = load_en && req_tvalid[gnt];
    end

    if (accept) begin
      tdata_d  = req_tdata[int'(gnt)*pDATA_WIDTH +: pDATA_WIDTH];
      tstrb_d  = req_tstrb[int'(gnt)*SW +: SW];
      tkeep_d  = req_tkeep[int'(gnt)*SW +: SW];
      tuser_d  = req_tuser[int'(gnt)*USER_W +: USER_W];
      tid_d    = gnt;
      tlast_d  = req_tlast[gnt];
      tvalid_d = 1'b1;
      if (req_tlast[gnt]) begin
        state_d  = IDLE;
        rr_ptr_d = next_ptr(gnt, pNUM_REQ);
      end else begin
        state_d = LOCKED;
        owner_d = gnt;
      end
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tkeep_q  <= '0;
      tuser_q  <= '0;
      tid_q    <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      tdata_q  <= tdata_d;
      tstrb_q  <= tstrb_d;
      tkeep_q  <= tkeep_d;
      tuser_q  <= tuser_d;
      tid_q    <= tid_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign as_is_tdata  = tdata_q;
  assign as_is_tstrb  = tstrb_q;
  assign as_is_tkeep  = tkeep_q;
  assign as_is_tuser  = tuser_q;
  assign as_is_tid    = tid_q;
  assign as_is_tlast  = tlast_q;
  assign as_is_tvalid = tvalid_q;
  assign cur_owner    = owner_q;
  assign busy         = (state_q == LOCKED);

endmodule

// File: tb/tb_fsic_is_tx_arbiter.sv
// Randomized bench for the TX arbiter.
// Reference: packet-level grant model plus per-requester sequence scoreboard.
module tb_fsic_is_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = W / 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            arb_en;
  logic [N*W-1:0]  req_tdata;
  logic [N*SW-1:0] req_tstrb;
  logic [N*SW-1:0] req_tkeep;
  logic [N*2-1:0]  req_tuser;
  logic [N-1:0]    req_tlast;
  logic [N-1:0]    req_tvalid;
  logic [N-1:0]    req_tready;
  logic [W-1:0]    as_is_tdata;
  logic [SW-1:0]   as_is_tstrb;
  logic [SW-1:0]   as_is_tkeep;
  logic [1:0]      as_is_tuser;
  logic [1:0]      as_is_tid;
  logic            as_is_tlast;
  logic            as_is_tvalid;
  logic            is_as_tready;
  logic [1:0]      cur_owner;
  logic            busy;

  fsic_is_tx_arbiter #(
    .pNUM_REQ    (N),
    .pDATA_WIDTH (W)
  ) dut (
    .axis_clk     (clk),
    .axis_rst_n   (rst_n),
    .arb_en       (arb_en),
    .req_tdata    (req_tdata),
    .req_tstrb    (req_tstrb),
    .req_tkeep    (req_tkeep),
    .req_tuser    (req_tuser),
    .req_tlast    (req_tlast),
    .req_tvalid   (req_tvalid),
    .req_tready   (req_tready),
    .as_is_tdata  (as_is_tdata),
    .as_is_tstrb  (as_is_tstrb),
    .as_is_tkeep  (as_is_tkeep),
    .as_is_tuser  (as_is_tuser),
    .as_is_tid    (as_is_tid),
    .as_is_tlast  (as_is_tlast),
    .as_is_tvalid (as_is_tvalid),
    .is_as_tready (is_as_tready),
    .cur_owner    (cur_owner),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Generators: each requester sends numbered beats in packets.
  int gen_cnt [N];
  int gen_rem [N];
  bit gen_mid [N];
  int exp_cnt [N];

  // Reference model of the arbiter at packet level.
  int          m_owner;
  int          m_ptr;
  bit          m_vld;
  logic [W-1:0]  m_data;
  logic [SW-1:0] m_strb;
  logic [SW-1:0] m_keep;
  logic [1:0]    m_user;
  int            m_tid;
  bit            m_last;

  int vprob, rprob, eprob;
  logic [N-1:0] mask;

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_vld   = 0;
    for (int r = 0; r < N; r++) begin
      if (gen_mid[r]) begin
        gen_mid[r] = 0;
        gen_rem[r] = $urandom_range(4, 1);
      end
      exp_cnt[r] = gen_cnt[r];
    end
  endtask

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      logic [3:0] s;
      s = 4'(gen_cnt[r] + r);
      req_tvalid[r] = (gen_mid[r] || mask[r]) &&
                      ($urandom_range(99) < vprob);
      req_tdata[r*W +: W]   = {8'(r), 24'(gen_cnt[r])};
      req_tstrb[r*SW +: SW] = s;
      req_tkeep[r*SW +: SW] = ~s;
      req_tuser[r*2 +: 2]   = 2'(gen_cnt[r]);
      req_tlast[r]          = (gen_rem[r] == 1);
    end
    arb_en       = ($urandom_range(99) < eprob);
    is_as_tready = ($urandom_range(99) < rprob);
  endtask

  task automatic cycle();
    int         g;
    int         c;
    bit         load;
    bit         acc;
    logic [N-1:0] exp_rdy;
    drive();
    #1;
    g = -1;
    if (m_owner >= 0) g = m_owner;
    else if (arb_en)
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (g < 0 && req_tvalid[c]) g = c;
      end
    load    = !m_vld || is_as_tready;
    exp_rdy = '0;
    if (g >= 0 && load) exp_rdy[g] = 1'b1;
    chk("ready", 64'(req_tready), 64'(exp_rdy));
    chk("tvalid", 64'(as_is_tvalid), 64'(m_vld));
    chk("busy", 64'(busy), 64'(m_owner >= 0));
    if (m_owner >= 0) chk("owner", 64'(cur_owner), 64'(m_owner));
    if (m_vld) begin
      chk("tdata", 64'(as_is_tdata), 64'(m_data));
      chk("side", 64'({as_is_tid, as_is_tlast, as_is_tuser,
                       as_is_tstrb, as_is_tkeep}),
          64'({2'(m_tid), m_last, m_user, m_strb, m_keep}));
      if (is_as_tready) begin
        chk("seq", 64'(as_is_tdata[23:0]), 64'(24'(exp_cnt[m_tid])));
        exp_cnt[m_tid]++;
      end
    end
    @(posedge clk);
    acc = (g >= 0) && load && req_tvalid[g];
    if (acc) begin
      m_vld  = 1;
      m_data = req_tdata[g*W +: W];
      m_strb = req_tstrb[g*SW +: SW];
      m_keep = req_tkeep[g*SW +: SW];
      m_user = req_tuser[g*2 +: 2];
      m_tid  = g;
      m_last = req_tlast[g];
      if (m_last) begin
        m_owner = -1;
        m_ptr   = (g + 1) % N;
      end else begin
        m_owner = g;
      end
      gen_cnt[g]++;
      gen_rem[g]--;
      gen_mid[g] = 1;
      if (gen_rem[g] == 0) begin
        gen_mid[g] = 0;
        gen_rem[g] = $urandom_range(4, 1);
      end
    end else if (is_as_tready) begin
      m_vld = 0;
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n      = 1'b0;
    req_tvalid = '1;
    #1;
    chk("rst_tvalid", 64'(as_is_tvalid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(req_tready), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    arb_en       = 1'b1;
    is_as_tready = 1'b1;
    req_tvalid   = '1;
    req_tdata    = '0;
    req_tstrb    = '0;
    req_tkeep    = '0;
    req_tuser    = '0;
    req_tlast    = '0;
    for (int r = 0; r < N; r++) begin
      gen_cnt[r] = r * 1000;
      gen_rem[r] = (r == 0) ? 3 : 2;
      gen_mid[r] = 0;
      exp_cnt[r] = gen_cnt[r];
    end
    m_owner = -1;
    m_ptr   = 0;
    m_vld   = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("init_ready", 64'(req_tready), 64'(0));
    chk("init_tvalid", 64'(as_is_tvalid), 64'(0));
    chk("init_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 5; p++) begin
      unique case (p)
        0: begin vprob = 100; rprob = 100; eprob = 100; mask = 4'hF; end
        1: begin vprob = 100; rprob = 100; eprob = 100; mask = 4'h2; end
        2: begin vprob = 60;  rprob = 50;  eprob = 100; mask = 4'hF; end
        3: begin vprob = 80;  rprob = 80;  eprob = 70;  mask = 4'h9; end
        default: begin vprob = 50; rprob = 70; eprob = 80; mask = 4'hF; end
      endcase
      for (int i = 0; i < 300; i++) begin
        if (p == 4 && (i == 97 || i == 211)) pulse_reset();
        cycle();
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
